reset_source: RTL



---
 rtl/reset_source.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/reset_source.sv
// Reset-request generator: merges POR, debounced button, software and watchdog
// sources into one stretched active-low request with a sticky cause register.
// Optional watchdog path is compiled in with `define RST_WATCHDOG_EN.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no reset pending, rst_req_n high, triggers accepted
//   HOLD    | rst_req_n low, hold_cnt counting down, waits for button release
//   RELEASE | rst_req_n low for one final cycle before returning to IDLE
module reset_source #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int MIN_PULSE       = 8,
   parameter int WDT_TIMEOUT     = 1000
) (
   input  logic       clk,
   input  logic       rst_in,
   input  logic       btn_n,
   input  logic       sw_rst_req,
   input  logic       wdt_en,
   input  logic       wdt_kick,
   input  logic       cause_clr,
   output logic       rst_req_n,
   output logic [3:0] rst_cause,
   output logic       busy
);

   localparam int HOLD_W = (MIN_PULSE > 1) ? $clog2(MIN_PULSE) : 1;
   localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(MIN_PULSE - 1);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HOLD    = 2'd1,
      ST_RELEASE = 2'd2
   } state_e;

   state_e            state_q;
   logic [HOLD_W-1:0] hold_cnt_q;
   logic              rst_req_n_q;
   logic              busy_q;
   logic [3:0]        rst_cause_q;

   logic [1:0]        rst_sync_q;
   logic [1:0]        btn_sync_q;
   logic              btn_db_q, btn_db_d;
   logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
   logic              btn_press;
   logic              wdt_fire;
   logic [3:0]        trig_vec;
   logic              trig_any;

   // Release of rst_in is only seen through this synchronizer; hold_cnt waits on it.
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         btn_sync_q <= 2'b11;
         btn_db_q   <= 1'b1;
         db_cnt_q   <= '0;
      end else begin
         btn_sync_q <= {btn_sync_q[0], btn_n};
         btn_db_q   <= btn_db_d;
         db_cnt_q   <= db_cnt_d;
      end
   end

   // Any sample agreeing with the debounced level restarts the count.
   always_comb begin
      btn_db_d  = btn_db_q;
      db_cnt_d  = '0;
      btn_press = 1'b0;
      if (btn_sync_q[1] != btn_db_q) begin
         if (db_cnt_q == DB_LAST) begin
            btn_db_d  = btn_sync_q[1];
            btn_press = ~btn_sync_q[1];
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

`ifdef RST_WATCHDOG_EN
   localparam int               WDT_W    = $clog2(WDT_TIMEOUT);
   localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_TIMEOUT - 1);

   logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;

   always_comb begin
      wdt_cnt_d = '0;
      wdt_fire  = 1'b0;
      if (wdt_en && !wdt_kick && (state_q == ST_IDLE)) begin
         if (wdt_cnt_q == WDT_LAST) begin
            wdt_fire = 1'b1;
         end else begin
            wdt_cnt_d = wdt_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         wdt_cnt_q <= '0;
      end else begin
         wdt_cnt_q <= wdt_cnt_d;
      end
   end
`else
   logic wdt_unused;
   assign wdt_unused = ^{wdt_en, wdt_kick, (WDT_TIMEOUT > 1)};
   assign wdt_fire   = 1'b0;
`endif

   assign trig_vec = {wdt_fire, sw_rst_req, btn_press, 1'b0};
   assign trig_any = |trig_vec;

   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         state_q     <= ST_HOLD;
         hold_cnt_q  <= HOLD_INIT;
         rst_req_n_q <= 1'b0;
         busy_q      <= 1'b1;
         rst_cause_q <= 4'b0001;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (trig_any) begin
                  state_q     <= ST_HOLD;
                  hold_cnt_q  <= HOLD_INIT;
                  rst_req_n_q <= 1'b0;
                  busy_q      <= 1'b1;
               end
            end
            ST_HOLD: begin
               // A pressed button parks HOLD at zero until it is released.
               if (hold_cnt_q == '0) begin
                  if (btn_db_q && rst_sync_q[1]) begin
                     state_q <= ST_RELEASE;
                  end
               end else if (rst_sync_q[1]) begin
                  hold_cnt_q <= hold_cnt_q - 1'b1;
               end
            end
            ST_RELEASE: begin
               state_q     <= ST_IDLE;
               rst_req_n_q <= 1'b1;
               busy_q      <= 1'b0;
            end
            default: begin
               state_q     <= ST_HOLD;
               hold_cnt_q  <= HOLD_INIT;
               rst_req_n_q <= 1'b0;
               busy_q      <= 1'b1;
            end
         endcase

         if ((state_q == ST_IDLE) && trig_any) begin
            rst_cause_q <= trig_vec;
         end else if (cause_clr) begin
            rst_cause_q <= 4'b0000;
         end
      end
   end

   assign rst_req_n = rst_req_n_q;
   assign busy      = busy_q;
   assign rst_cause = rst_cause_q;

endmodule
